// File: rtl/code_converter_pipe.sv
// Two-stage pipelined multi-digit code converter: binary/Gray and BCD/excess-3 in both
// directions, with valid/ready handshakes, invalid-digit flagging and a saturating error count.
module code_converter_pipe #(
  parameter int DIGITS = 2,
  parameter int ERR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  input  logic                  clr_err,
  output logic [ERR_W-1:0]      err_count
);

  localparam int W = 4 * DIGITS;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    MODE_B2G    = 2'b00,
    MODE_G2B    = 2'b01,
    MODE_BCD2X3 = 2'b10,
    MODE_X32BCD = 2'b11
  } mode_e;

  logic             s1_valid_q;
  logic [W-1:0]     s1_data_q;
  mode_e            s1_mode_q;
  logic             s2_valid_q;
  logic [W-1:0]     s2_data_q;
  logic             s2_err_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;

  logic             s2_ready;
  logic             in_hs;
  logic [W-1:0]     conv_data;
  logic             conv_err;
  logic             acc;
  logic [3:0]       nib;

  // Ready is derived only from registered valids and out_ready, never from in_valid.
  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign in_hs    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_B2G;
    end else if (in_hs) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= in_data;
      s1_mode_q  <= mode_e'(mode);
    end else if (s2_ready) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Decimal modes treat every nibble independently; no carry crosses digit boundaries.
  always_comb begin
    conv_data = '0;
    conv_err  = 1'b0;
    acc       = 1'b0;
    nib       = '0;
    case (s1_mode_q)
      MODE_B2G: conv_data = s1_data_q ^ (s1_data_q >> 1);
      MODE_G2B: begin
        for (int i = W - 1; i >= 0; i--) begin
          acc          = acc ^ s1_data_q[i];
          conv_data[i] = acc;
        end
      end
      MODE_BCD2X3: begin
        for (int d = 0; d < DIGITS; d++) begin
          nib = s1_data_q[4*d +: 4];
          if (nib <= 4'd9) begin
            conv_data[4*d +: 4] = nib + 4'd3;
          end else begin
            conv_data[4*d +: 4] = 4'hF;
            conv_err            = 1'b1;
          end
        end
      end
      default: begin
        for (int d = 0; d < DIGITS; d++) begin
          nib = s1_data_q[4*d +: 4];
          if (nib >= 4'd3 && nib <= 4'd12) begin
            conv_data[4*d +: 4] = nib - 4'd3;
          end else begin
            conv_data[4*d +: 4] = 4'hF;
            conv_err            = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= conv_data;
        s2_err_q  <= conv_err;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

  // Clear has priority over a coincident increment; the count sticks at its maximum.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = '0;
    end else if (out_valid && out_ready && out_err && err_count_q != ERR_MAX) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

endmodule
